// File: rtl/arm_pipelined_decode_execute_stage.sv
// Decode -> Execute pipeline register for a 5-stage ARM-style core, plus the
// Execute-stage operand forwarding muxes.
//
// Optional build macro: ARM_PIPE_DE_PERF_EN adds two saturating 16-bit
// performance counters (bubbles inserted, operands forwarded). Without it the
// counter ports and logic are absent.
//
// Pipeline valid semantics: there is no backpressure. Every rising edge moves
// the Decode-stage bundle into Execute. o_Valid_E=1 means Execute holds a real
// instruction. A flush turns that slot into a bubble: control cleared, cond=AL,
// valid=0. Data and addresses still load so the hazard unit sees stable values.
module arm_pipelined_decode_execute_stage #(
    parameter int BusWidth = 32
) (
    input  logic                i_CLK,
    input  logic                i_NRESET,
    input  logic                i_Flush_Execute,
    input  logic [9:0]          i_Ctrl_D,
    input  logic [3:0]          i_Cond_D,
    input  logic [BusWidth-1:0] i_RD1_D,
    input  logic [BusWidth-1:0] i_RD2_D,
    input  logic [BusWidth-1:0] i_ExtImm_D,
    input  logic [3:0]          i_RA1_D,
    input  logic [3:0]          i_RA2_D,
    input  logic [3:0]          i_WA3_D,
    input  logic [1:0]          i_Forward_A_E,
    input  logic [1:0]          i_Forward_B_E,
    input  logic [BusWidth-1:0] i_ALUResult_M,
    input  logic [BusWidth-1:0] i_Result_W,
    output logic [9:0]          o_Ctrl_E,
    output logic [3:0]          o_Cond_E,
    output logic [3:0]          o_RA1_E,
    output logic [3:0]          o_RA2_E,
    output logic [3:0]          o_WA3_E,
    output logic [BusWidth-1:0] o_SrcA_E,
    output logic [BusWidth-1:0] o_SrcB_E,
    output logic [BusWidth-1:0] o_WriteData_E,
    output logic                o_Valid_E
`ifdef ARM_PIPE_DE_PERF_EN
    ,
    output logic [15:0]         o_Bubble_Count,
    output logic [15:0]         o_Fwd_Count
`endif
);

    localparam logic [3:0]  CondAl   = 4'hE;
    localparam logic [1:0]  FwdRegs  = 2'b00;
    localparam logic [1:0]  FwdWb    = 2'b01;
    localparam logic [1:0]  FwdMem   = 2'b10;

    logic [9:0]          ctrl_e;
    logic [3:0]          cond_e;
    logic                valid_e;
    logic [BusWidth-1:0] rd1_e;
    logic [BusWidth-1:0] rd2_e;
    logic [BusWidth-1:0] ext_imm_e;
    logic [3:0]          ra1_e;
    logic [3:0]          ra2_e;
    logic [3:0]          wa3_e;
    logic [BusWidth-1:0] fwd_a;
    logic [BusWidth-1:0] fwd_b;

    // Execute-stage register: reset wins over flush; flush only kills control.
    always_ff @(posedge i_CLK or negedge i_NRESET) begin
        if (!i_NRESET) begin
            ctrl_e    <= '0;
            cond_e    <= CondAl;
            valid_e   <= 1'b0;
            rd1_e     <= '0;
            rd2_e     <= '0;
            ext_imm_e <= '0;
            ra1_e     <= '0;
            ra2_e     <= '0;
            wa3_e     <= '0;
        end else begin
            rd1_e     <= i_RD1_D;
            rd2_e     <= i_RD2_D;
            ext_imm_e <= i_ExtImm_D;
            ra1_e     <= i_RA1_D;
            ra2_e     <= i_RA2_D;
            wa3_e     <= i_WA3_D;
            if (i_Flush_Execute) begin
                ctrl_e  <= '0;
                cond_e  <= CondAl;
                valid_e <= 1'b0;
            end else begin
                ctrl_e  <= i_Ctrl_D;
                cond_e  <= i_Cond_D;
                valid_e <= 1'b1;
            end
        end
    end

    // Forwarding muxes: selects act in the cycle they arrive, no registering.
    always_comb begin
        fwd_a = rd1_e;
        fwd_b = rd2_e;
        case (i_Forward_A_E)
            FwdWb:   fwd_a = i_Result_W;
            FwdMem:  fwd_a = i_ALUResult_M;
            default: fwd_a = rd1_e;
        endcase
        case (i_Forward_B_E)
            FwdWb:   fwd_b = i_Result_W;
            FwdMem:  fwd_b = i_ALUResult_M;
            default: fwd_b = rd2_e;
        endcase
    end

    assign o_Ctrl_E      = ctrl_e;
    assign o_Cond_E      = cond_e;
    assign o_Valid_E     = valid_e;
    assign o_RA1_E       = ra1_e;
    assign o_RA2_E       = ra2_e;
    assign o_WA3_E       = wa3_e;
    assign o_SrcA_E      = fwd_a;
    assign o_WriteData_E = fwd_b;
    // ALUSrc (bit 9) picks the immediate over the forwarded register operand.
    assign o_SrcB_E      = ctrl_e[9] ? ext_imm_e : fwd_b;

`ifdef ARM_PIPE_DE_PERF_EN
    logic [15:0] bubble_cnt;
    logic [15:0] fwd_cnt;
    logic        fwd_used;

    assign fwd_used = (i_Forward_A_E == FwdWb) || (i_Forward_A_E == FwdMem) ||
                      (i_Forward_B_E == FwdWb) || (i_Forward_B_E == FwdMem);

    // Saturating event counters: bubbles inserted and real forwards taken.
    always_ff @(posedge i_CLK or negedge i_NRESET) begin
        if (!i_NRESET) begin
            bubble_cnt <= '0;
            fwd_cnt    <= '0;
        end else begin
            if (i_Flush_Execute && (bubble_cnt != 16'hFFFF)) begin
                bubble_cnt <= bubble_cnt + 16'd1;
            end
            if (valid_e && fwd_used && (fwd_cnt != 16'hFFFF)) begin
                fwd_cnt <= fwd_cnt + 16'd1;
            end
        end
    end

    assign o_Bubble_Count = bubble_cnt;
    assign o_Fwd_Count    = fwd_cnt;
`endif

endmodule

// File: doc/arm_pipelined_decode_execute_stage.md
ARM_PIPELINED_DECODE_EXECUTE_STAGE -- requirements
Module: arm_pipelined_decode_execute_stage

Interface
REQ-001 SHALL have parameter BusWidth, default 32, datapath width.
REQ-002 SHALL have port i_CLK  input  1  single clock, all state rising-edge.
REQ-003 SHALL have port i_NRESET  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_Flush_Execute  input  1  bubble request from hazard unit.
REQ-005 SHALL have port i_Ctrl_D  input  10  decode control {ALUSrc[9], ALUControl[8:7], FlagWrite[6:5], PCSrc[4], Branch[3], MemToReg[2], MemWrite[1], RegWrite[0]}.
REQ-006 SHALL have port i_Cond_D  input  4  condition field.
REQ-007 SHALL have ports i_RD1_D, i_RD2_D, i_ExtImm_D  input  BusWidth  register-file reads, extended immediate.
REQ-008 SHALL have ports i_RA1_D, i_RA2_D, i_WA3_D  input  4  source/destination register addresses.
REQ-009 SHALL have ports i_Forward_A_E, i_Forward_B_E  input  2  forward selects from hazard unit.
REQ-010 SHALL have ports i_ALUResult_M, i_Result_W  input  BusWidth  Memory/WriteBack forward sources.
REQ-011 SHALL have port o_Ctrl_E  output  10  registered control, same packing as i_Ctrl_D.
REQ-012 SHALL have port o_Cond_E  output  4  registered condition.
REQ-013 SHALL have ports o_RA1_E, o_RA2_E, o_WA3_E  output  4  registered addresses (RA1/RA2 feed hazard unit).
REQ-014 SHALL have ports o_SrcA_E, o_SrcB_E, o_WriteData_E  output  BusWidth  ALU operands and store data.
REQ-015 SHALL have port o_Valid_E  output  1  Execute holds a real instruction.

Function
REQ-016 SHALL capture all *_D inputs into Execute registers every rising i_CLK edge (no stall; one-cycle latency).
REQ-017 SHALL, when i_Flush_Execute=1 at an edge, load o_Ctrl_E=0, o_Cond_E=4'hE (AL), o_Valid_E=0; data/address registers still load from *_D.
REQ-018 SHALL otherwise set o_Valid_E=1 on each edge.
REQ-019 SHALL compute forwarded A combinationally: select 00 RD1_E, 01 i_Result_W, 10 i_ALUResult_M, 11 RD1_E.
REQ-020 SHALL compute forwarded B identically from RD2_E with i_Forward_B_E.
REQ-021 SHALL drive o_SrcA_E = forwarded A, o_WriteData_E = forwarded B.
REQ-022 SHALL drive o_SrcB_E = registered ExtImm when o_Ctrl_E[9]=1, else forwarded B.
REQ-023 SHALL apply forward selects in the same cycle they arrive (zero added latency, no registering of selects).
REQ-024 SHALL keep address outputs valid during a bubble so the hazard unit sees stable (harmless) addresses.

Reset
REQ-025 SHALL, while i_NRESET=0, immediately force all registers to 0 except o_Cond_E=4'hE; o_Valid_E=0.
REQ-026 SHALL give reset priority over flush; first edge after release captures *_D normally.
REQ-027 SHALL, on reset assertion mid-operation, discard the in-flight instruction with no partial output.

Configuration
REQ-028 SHALL, with macro ARM_PIPE_DE_PERF_EN defined, add outputs o_Bubble_Count and o_Fwd_Count (16 bits each, reset 0).
REQ-029 SHALL, under ARM_PIPE_DE_PERF_EN, increment o_Bubble_Count on each edge with i_Flush_Execute=1, and o_Fwd_Count on each edge where o_Valid_E=1 and either select is 01/10; both saturate at 16'hFFFF.
REQ-030 SHALL, without ARM_PIPE_DE_PERF_EN, omit the counter ports and logic entirely; all other behaviour identical.

Verification
REQ-031 SHALL cover: release reset, drive i_Ctrl_D=10'h001, i_RD1_D=5 -> next edge o_Ctrl_E=10'h001, o_SrcA_E=5, o_Valid_E=1.
REQ-032 SHALL cover: i_Flush_Execute=1 with i_Ctrl_D=10'h3FF -> o_Ctrl_E=0, o_Cond_E=4'hE, o_Valid_E=0, o_WA3_E=i_WA3_D.
REQ-033 SHALL cover: RD1_E=1, i_ALUResult_M=7, i_Result_W=9, i_Forward_A_E stepped 00/01/10/11 -> o_SrcA_E 1/9/7/1 same cycle.
REQ-034 SHALL cover: ALUSrc=1, ExtImm=0x10, i_Forward_B_E=10, ALUResult_M=0x20 -> o_SrcB_E=0x10, o_WriteData_E=0x20.
REQ-035 SHALL cover: i_NRESET low between edges during valid instruction -> outputs reset without clock edge; flush+reset together -> reset values.
REQ-036 SHALL cover (PERF_EN): 70000 consecutive flushes -> o_Bubble_Count=16'hFFFF, holds.
